// File: rtl/pe_pkg.sv
// Purpose : shared types and helpers for the saturating systolic MAC element.
// Latency : n/a (types, constants and constant functions only).
// Backpress: n/a.
// Contents: pe_state_e FSM encoding (IDLE=0, ACCUM=1, EMIT=2),
//           sat_max/sat_min returning the signed extremes of a given width.
package pe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } pe_state_e;

  // Wide enough for any accumulator width we expect to instantiate; callers
  // truncate the return value to their own width.
  localparam int unsigned SAT_FN_W = 256;

  // Largest positive value of a signed number of 'width' bits (0111...1).
  function automatic logic [SAT_FN_W-1:0] sat_max(input int unsigned width);
    logic [SAT_FN_W-1:0] one;
    one     = {{(SAT_FN_W-1){1'b0}}, 1'b1};
    sat_max = (one << (width - 1)) - one;
  endfunction

  // Most negative value of a signed number of 'width' bits (1000...0 after truncation).
  function automatic logic [SAT_FN_W-1:0] sat_min(input int unsigned width);
    logic [SAT_FN_W-1:0] one;
    one     = {{(SAT_FN_W-1){1'b0}}, 1'b1};
    sat_min = one << (width - 1);
  endfunction

endpackage

// File: rtl/pe_sat_add.sv
// Purpose : accumulator adder with overflow detect and optional saturation.
// Latency : combinational (0 cycles).
// Backpress: none; pure function of its inputs.
// Ports   : acc_i   - current accumulator (signed, W bits)
//           prod_i  - sign-extended product (signed, W bits)
//           sat_en_i- 1 clamps to the signed extremes on overflow, 0 wraps
//           next_acc_o - value to load into the accumulator
//           ovf_o   - the W-bit result does not represent the true sum
module pe_sat_add
  import pe_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] prod_i,
  input  logic         sat_en_i,
  output logic [W-1:0] next_acc_o,
  output logic         ovf_o
);

  localparam logic [W-1:0] SAT_MAX = W'(sat_max(W));
  localparam logic [W-1:0] SAT_MIN = W'(sat_min(W));

  logic [W:0] sum;

  // One guard bit: bit W carries the true sign, so a mismatch with bit W-1
  // means the sum escaped the W-bit range.
  assign sum   = {acc_i[W-1], acc_i} + {prod_i[W-1], prod_i};
  assign ovf_o = sum[W] ^ sum[W-1];

  always_comb begin
    next_acc_o = sum[W-1:0];
    if (ovf_o && sat_en_i) begin
      next_acc_o = sum[W] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/pe_sat_mac.sv
// Purpose : systolic PE - programmable-length signed dot product with optional
//           bias preload, wrap/saturate accumulation and sticky overflow.
// Latency : operand forward 1 cycle; result_valid 2 edges after the last beat.
// Backpress: none; every in_valid beat is consumed (accumulated in ACCUM) and
//           forwarded, start always wins and aborts any op in flight.
// Ports   : clk/reset (async, active-high); start + k_len/bias_en/bias/sat_en
//           op setup; in_valid/a/b operand beats; out_valid/out_a/out_b
//           forwarded operands; result/result_valid/overflow per-op result;
//           busy high while in ACCUM or EMIT.
module pe_sat_mac
  import pe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BUS_W  = 64,
  parameter int K_MAX  = 16,
  localparam int CNT_W = $clog2(K_MAX + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CNT_W-1:0]         k_len,
  input  logic                     bias_en,
  input  logic signed [BUS_W-1:0]  bias,
  input  logic                     sat_en,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] out_a,
  output logic signed [DATA_W-1:0] out_b,
  output logic                     out_valid,
  output logic signed [BUS_W-1:0]  result,
  output logic                     result_valid,
  output logic                     overflow,
  output logic                     busy
);

  localparam logic [CNT_W-1:0] K_MAX_C = CNT_W'(K_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  pe_state_e          state_q;
  logic [BUS_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic               sat_q;
  logic [BUS_W-1:0]   result_q;
  logic               result_valid_q;
  logic               overflow_q;
  logic [DATA_W-1:0]  out_a_q;
  logic [DATA_W-1:0]  out_b_q;
  logic               out_valid_q;

  logic signed [2*DATA_W-1:0] prod;
  logic [BUS_W-1:0]   prod_ext;
  logic [BUS_W-1:0]   acc_d;
  logic               add_ovf;
  logic [CNT_W-1:0]   cnt_d;
  logic [BUS_W-1:0]   acc_init_d;

  // Signed cast of a signed operand sign-extends to the accumulator width.
  assign prod     = a * b;
  assign prod_ext = BUS_W'(prod);

  assign cnt_d      = (k_len > K_MAX_C) ? K_MAX_C : k_len;
  assign acc_init_d = bias_en ? bias : '0;

  pe_sat_add #(
    .W (BUS_W)
  ) u_add (
    .acc_i      (acc_q),
    .prod_i     (prod_ext),
    .sat_en_i   (sat_q),
    .next_acc_o (acc_d),
    .ovf_o      (add_ovf)
  );

  // Operand forwarding runs regardless of FSM state so the array keeps
  // streaming even while this PE is idle or emitting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        out_a_q <= a;
        out_b_q <= b;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      acc_q          <= '0;
      cnt_q          <= '0;
      ovf_q          <= 1'b0;
      sat_q          <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
        end
        ST_ACCUM: begin
          if (in_valid) begin
            acc_q <= acc_d;
            ovf_q <= ovf_q | add_ovf;
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state_q <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          result_q       <= acc_q;
          overflow_q     <= ovf_q;
          result_valid_q <= 1'b1;
          state_q        <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      // start overrides whatever the case above scheduled for the op state:
      // from ACCUM it aborts silently, from EMIT the emit still lands
      // (result registers are untouched here) and the new op begins.
      // A beat arriving with start is only forwarded.
      if (start) begin
        acc_q   <= acc_init_d;
        cnt_q   <= cnt_d;
        ovf_q   <= 1'b0;
        sat_q   <= sat_en;
        state_q <= (k_len == '0) ? ST_EMIT : ST_ACCUM;
      end
    end
  end

  assign out_a        = out_a_q;
  assign out_b        = out_b_q;
  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign overflow     = overflow_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
